// File: rtl/cv32e40x_mult_arbiter_pkg.sv
// Shared types for the multiplier arbiter: operator encoding, port identifiers
// and a small helper for round-robin priority hand-over.
package cv32e40x_mult_arbiter_pkg;

    // Multiplier operator; MUL_M32 is single-cycle, MUL_H is the 4-cycle high-half multiply
    typedef enum logic [0:0] {
        MUL_M32 = 1'b0,
        MUL_H   = 1'b1
    } mul_opcode_e;

    // Requester identifiers used for the grant owner and the priority pointer
    typedef enum logic {
        MULT_ARB_P0 = 1'b0,
        MULT_ARB_P1 = 1'b1
    } mult_arb_port_e;

    localparam int unsigned MULT_ARB_DATA_W = 32;

    // The port that did not just complete gets priority next
    function automatic mult_arb_port_e arb_other(input mult_arb_port_e p);
        return (p == MULT_ARB_P0) ? MULT_ARB_P1 : MULT_ARB_P0;
    endfunction

endpackage

// File: rtl/cv32e40x_mult_arbiter_if.sv
// Bundle of both requester ports, the multiplier-facing port and the debug
// outputs of the multiplier arbiter.
interface cv32e40x_mult_arbiter_if;
    import cv32e40x_mult_arbiter_pkg::*;

    // Requester port 0 (core EX stage)
    logic           req0_valid_i;
    mul_opcode_e    req0_operator_i;
    logic [1:0]     req0_short_signed_i;
    logic [31:0]    req0_op_a_i;
    logic [31:0]    req0_op_b_i;
    logic           req0_ready_i;
    logic           req0_ready_o;
    logic           req0_valid_o;

    // Requester port 1 (eXtension issue path)
    logic           req1_valid_i;
    mul_opcode_e    req1_operator_i;
    logic [1:0]     req1_short_signed_i;
    logic [31:0]    req1_op_a_i;
    logic [31:0]    req1_op_b_i;
    logic           req1_ready_i;
    logic           req1_ready_o;
    logic           req1_valid_o;

    // Shared result back to the requesters
    logic [31:0]    result_o;

    // Multiplier side
    logic           mult_valid_o;
    mul_opcode_e    mult_operator_o;
    logic [1:0]     mult_short_signed_o;
    logic [31:0]    mult_op_a_o;
    logic [31:0]    mult_op_b_o;
    logic           mult_ready_o;
    logic [31:0]    mult_result_i;
    logic           mult_ready_i;
    logic           mult_valid_i;

    // Debug / trace
    mult_arb_port_e owner_o;
    logic           locked_o;

    // Arbiter view
    modport slave (
        input  req0_valid_i, req0_operator_i, req0_short_signed_i, req0_op_a_i, req0_op_b_i, req0_ready_i,
        output req0_ready_o, req0_valid_o,
        input  req1_valid_i, req1_operator_i, req1_short_signed_i, req1_op_a_i, req1_op_b_i, req1_ready_i,
        output req1_ready_o, req1_valid_o,
        output result_o,
        output mult_valid_o, mult_operator_o, mult_short_signed_o, mult_op_a_o, mult_op_b_o, mult_ready_o,
        input  mult_result_i, mult_ready_i, mult_valid_i,
        output owner_o, locked_o
    );

    // Environment view: requesters plus the multiplier
    modport master (
        output req0_valid_i, req0_operator_i, req0_short_signed_i, req0_op_a_i, req0_op_b_i, req0_ready_i,
        input  req0_ready_o, req0_valid_o,
        output req1_valid_i, req1_operator_i, req1_short_signed_i, req1_op_a_i, req1_op_b_i, req1_ready_i,
        input  req1_ready_o, req1_valid_o,
        input  result_o,
        input  mult_valid_o, mult_operator_o, mult_short_signed_o, mult_op_a_o, mult_op_b_o, mult_ready_o,
        output mult_result_i, mult_ready_i, mult_valid_i,
        input  owner_o, locked_o
    );

endinterface

// File: rtl/cv32e40x_mult_arbiter_sva.sv
// Protocol checks for the multiplier arbiter, bound into every instance.
module cv32e40x_mult_arbiter_sva
    import cv32e40x_mult_arbiter_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    input logic           i_locked,
    input mult_arb_port_e i_owner,
    input logic           i_req0_valid,
    input logic           i_req1_valid,
    input logic           i_req0_ready,
    input logic           i_req1_ready
);

    // The lock owner must keep its request up, otherwise the multiplier FSM is left mid-operation
    a_owner_holds_valid: assert property (
        @(posedge clk) disable iff (!rst_n)
        i_locked |-> ((i_owner == MULT_ARB_P0) ? i_req0_valid : i_req1_valid)
    );

    // Only the granted port can ever be handed the multiplier handshake
    a_single_ready: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(i_req0_ready && i_req1_ready)
    );

endmodule

bind cv32e40x_mult_arbiter cv32e40x_mult_arbiter_sva u_mult_arbiter_sva (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_locked     (r_locked),
    .i_owner      (r_owner),
    .i_req0_valid (w_req0_valid),
    .i_req1_valid (w_req1_valid),
    .i_req0_ready (w_req0_ready),
    .i_req1_ready (w_req1_ready)
);

// File: rtl/cv32e40x_mult_arbiter.sv
// Two-port arbiter in front of the shared multiplier. Picks a port (round-robin
// or fixed priority), muxes its operands into the multiplier, routes the
// handshake back and locks the grant across a multicycle MUL_H.
module cv32e40x_mult_arbiter
    import cv32e40x_mult_arbiter_pkg::*;
#(
    parameter bit             RR_EN    = 1'b1,
    parameter mult_arb_port_e PRIO_RST = MULT_ARB_P0
) (
    input logic                    clk,
    input logic                    rst_n,
    cv32e40x_mult_arbiter_if.slave bus
);

    logic           r_locked;
    mult_arb_port_e r_owner;
    mult_arb_port_e r_prio;

    mult_arb_port_e w_grant;
    logic           w_req0_valid;
    logic           w_req1_valid;
    logic           w_req0_ready;
    logic           w_req1_ready;
    logic           w_mult_valid;
    logic           w_mult_ready;
    logic           w_done;

    assign w_req0_valid = bus.req0_valid_i;
    assign w_req1_valid = bus.req1_valid_i;

    // Grant selection: a held lock wins, then a lone requester, then the priority pointer
    always_comb begin
        w_grant = r_prio;
        if (r_locked) begin
            w_grant = r_owner;
        end else if (w_req0_valid && !w_req1_valid) begin
            w_grant = MULT_ARB_P0;
        end else if (!w_req0_valid && w_req1_valid) begin
            w_grant = MULT_ARB_P1;
        end else if (w_req0_valid && w_req1_valid) begin
            w_grant = RR_EN ? r_prio : MULT_ARB_P0;
        end
    end

    // Operand and handshake mux towards the multiplier
    always_comb begin
        if (w_grant == MULT_ARB_P1) begin
            w_mult_valid            = w_req1_valid;
            w_mult_ready            = bus.req1_ready_i;
            bus.mult_operator_o     = bus.req1_operator_i;
            bus.mult_short_signed_o = bus.req1_short_signed_i;
            bus.mult_op_a_o         = bus.req1_op_a_i;
            bus.mult_op_b_o         = bus.req1_op_b_i;
        end else begin
            w_mult_valid            = w_req0_valid;
            w_mult_ready            = bus.req0_ready_i;
            bus.mult_operator_o     = bus.req0_operator_i;
            bus.mult_short_signed_o = bus.req0_short_signed_i;
            bus.mult_op_a_o         = bus.req0_op_a_i;
            bus.mult_op_b_o         = bus.req0_op_b_i;
        end
    end

    assign bus.mult_valid_o = w_mult_valid;
    assign bus.mult_ready_o = w_mult_ready;

    // Return path: only the granted port sees the multiplier handshake
    always_comb begin
        w_req0_ready     = 1'b0;
        w_req1_ready     = 1'b0;
        bus.req0_valid_o = 1'b0;
        bus.req1_valid_o = 1'b0;
        if (w_grant == MULT_ARB_P1) begin
            w_req1_ready     = bus.mult_ready_i;
            bus.req1_valid_o = bus.mult_valid_i;
        end else begin
            w_req0_ready     = bus.mult_ready_i;
            bus.req0_valid_o = bus.mult_valid_i;
        end
    end

    assign bus.req0_ready_o = w_req0_ready;
    assign bus.req1_ready_o = w_req1_ready;
    assign bus.result_o     = bus.mult_result_i;

    // A transfer finishes when the multiplier presents a result the owner accepts
    assign w_done = w_mult_valid && bus.mult_valid_i && w_mult_ready;

    // Lock, owner and priority state; an unfinished accepted request pins the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
            r_owner  <= PRIO_RST;
            r_prio   <= PRIO_RST;
        end else begin
            if (!r_locked && w_mult_valid && !w_done) begin
                r_locked <= 1'b1;
                r_owner  <= w_grant;
            end else if (r_locked && w_done) begin
                r_locked <= 1'b0;
            end
            if (w_done && RR_EN) begin
                r_prio <= arb_other(w_grant);
            end
        end
    end

    assign bus.owner_o  = r_owner;
    assign bus.locked_o = r_locked;

endmodule
